sipo_frame_ctrl: RTL
====================

// Module: sipo_frame_ctrl
//
// PURPOSE
// - Frame controller that sequences a serial-in, parallel-out shift register.
// - Qualifies serial bits, detects frame start and counts bits to DATA_WIDTH.
// - Transfers each completed word into a separate output holding register.
// - Presents that word on a valid/ready handshake to the downstream consumer.
// - Sits between a serial bit source and a parallel consumer.
//
// PARAMETERS
// - DATA_WIDTH  16  Bits per frame word. Legal for DATA_WIDTH >= 1; the shift must not index [W-2:0].
//
// PORTS
// - clk         in   1   Single clock; all state changes on posedge.
// - resetn      in   1   Asynchronous, active-low reset.
// - din         in   1   Serial data bit, MSB first.
// - din_en      in   1   din is valid this cycle.
// - start       in   1   Frame start; honoured only with din_en=1; that bit is data bit 0 (MSB).
// - dout        out  W   Held parallel word.
// - dout_valid  out  1   dout holds an unconsumed word.
// - dout_ready  in   1   Consumer accepts dout when dout_valid=1.
// - busy        out  1   A frame is in progress (state != IDLE).
// - overrun     out  1   One-cycle pulse: a completed word was dropped.
// - parity_err  out  1   Parity result for the held word; constant 0 without the macro.
//
// BEHAVIOUR
// - Reset: state=IDLE, shreg=0, bit count=0, dout=0, dout_valid=0, busy=0, overrun=0, parity_err=0.
// - Reset is asynchronous and takes effect mid-frame; any partial frame is discarded.
// - Bit count width is $clog2(DATA_WIDTH+1).
// - Shift operation on an accepted bit: shreg <= (shreg<<1) | din, truncated to W bits.
// - FSM states: IDLE, SHIFT, and PARITY (PARITY exists only with the macro).
// - IDLE:
//   - start & din_en: shift the bit in; count=1; go to SHIFT.
//   - If W==1, complete the frame immediately instead (see Completion).
//   - Anything else is ignored.
// - SHIFT:
//   - din_en=0: hold all state. Gaps of any length are allowed.
//   - din_en=1, start=0: shift the bit in; count+1.
//   - The W-th accepted bit completes the frame.
//   - start & din_en: abort the partial frame; this bit becomes bit 0; count=1. No overrun, no output.
// - Completion: the next state is IDLE and the word is loaded into dout.
//   - dout_valid rises the cycle after the clock edge that accepts the final bit (latency 1).
//   - The word loaded is the shift value including the final bit.
// - Handshake:
//   - A transfer occurs when dout_valid & dout_ready.
//   - dout is stable while dout_valid=1 and no transfer has occurred.
//   - After a transfer, dout_valid falls the next cycle unless a new word loads on the same edge.
//   - If a new word loads on the transfer edge, dout_valid stays 1 and dout takes the new word.
// - Overrun:
//   - Trigger: completion while dout_valid=1 and dout_ready=0.
//   - The new word is dropped; dout and dout_valid are unchanged.
//   - overrun=1 for exactly one cycle.
//   - The FSM still returns to IDLE.
// - Back-to-back frames: start may arrive in the first cycle after completion, with no bubble.
// - Outputs dout, dout_valid, busy, overrun and parity_err are all registered.
//
// CONFIGURATION
// - Macro: SIPO_FRAME_PARITY_EN.
// - Defined:
//   - After W data bits, SHIFT moves to PARITY; the next din_en bit is an even-parity bit.
//   - Completion occurs on the parity bit, not on the W-th data bit.
//   - parity_err = ^{word, parity bit}; it loads together with dout and is held with it.
//   - start & din_en in PARITY: abort and restart, as in SHIFT.
// - Undefined:
//   - No PARITY state; completion occurs on the W-th data bit.
//   - parity_err is tied to 0.
//
// TESTING
// - Reset mid-frame:
//   - Shift 5 bits, pulse resetn low asynchronously.
//   - Expect all outputs 0 and busy=0 at once; the next full frame is received correctly.
// - Basic frame (W=16):
//   - start on the first bit, send 0xA5C3 MSB first with din_en=1 for 16 cycles.
//   - Expect dout=16'hA5C3, dout_valid=1 exactly one cycle after the 16th bit edge.
// - Gapped input:
//   - Send 0x1234 with din_en low in random cycles.
//   - Expect dout=16'h1234 and busy=1 throughout the frame.
// - Back-pressure:
//   - Hold dout_ready=0 and send 0x00FF, then 0xFF00.
//   - Expect overrun pulse=1 for one cycle and dout still 0x00FF.
//   - Then pulse dout_ready and expect dout_valid to fall.
// - Restart and same-cycle transfer:
//   - Send 7 bits, then start with a new 0xBEEF frame. Expect dout=0xBEEF.
//   - Assert dout_ready on the edge where the next frame completes. Expect dout_valid to stay 1 with the new word.
// - SIPO_FRAME_PARITY_EN:
//   - Send 0x0001 with parity bit 1: expect parity_err=0.
//   - Send 0x0001 with parity bit 0: expect parity_err=1.
//   - In both cases dout_valid rises one cycle after the parity bit.
//   - Additionally run W=1 with 1-bit frames.

Source files
------------

// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl: frame controller for a serial-in, parallel-out shift register.
// Qualifies serial bits (MSB first), detects frame start, counts to DATA_WIDTH,
// and presents each completed word on a valid/ready handshake.
//
// Optional feature macro: SIPO_FRAME_PARITY_EN
//   defined   : an even-parity bit follows the W data bits; parity_err is held with dout.
//   undefined : completion on the W-th data bit; parity_err tied to 0.
//
// Ports:
//   clk         in   clock, all state changes on posedge
//   resetn      in   asynchronous active-low reset
//   din         in   serial data bit, MSB first
//   din_en      in   din valid this cycle
//   start       in   frame start (honoured only with din_en)
//   dout        out  held parallel word
//   dout_valid  out  dout holds an unconsumed word
//   dout_ready  in   consumer accepts dout when dout_valid
//   busy        out  frame in progress
//   overrun     out  one-cycle pulse, a completed word was dropped
//   parity_err  out  parity result for the held word
module sipo_frame_ctrl #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  din,
  input  logic                  din_en,
  input  logic                  start,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  busy,
  output logic                  overrun,
  output logic                  parity_err
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1
`ifdef SIPO_FRAME_PARITY_EN
    ,PARITY = 2'd2
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    shreg_q, shreg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    dout_d;
  logic            valid_d;
  logic            busy_d;
  logic            overrun_d;
  logic            perr_d;

  logic            data_acc;
  logic [W-1:0]    word_n;
  logic [CW-1:0]   cnt_n;
  logic            load;
  logic [W-1:0]    load_word;
  logic            load_perr;
  logic [W-1:0]    shifted;

  // Shift without slicing so that W==1 stays legal: keep the low W bits of {shreg, din}.
  assign shifted = W'({shreg_q, din});

  // Register bank: FSM state, datapath and all outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      dout       <= dout_d;
      dout_valid <= valid_d;
      busy       <= busy_d;
      overrun    <= overrun_d;
      parity_err <= perr_d;
    end
  end

  // Next-state, datapath and output logic.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    dout_d    = dout;
    valid_d   = dout_valid & ~dout_ready;
    overrun_d = 1'b0;
    perr_d    = parity_err;
    data_acc  = 1'b0;
    word_n    = shifted;
    cnt_n     = cnt_q + CW'(1);
    load      = 1'b0;
    load_word = shreg_q;
    load_perr = 1'b0;

    // start with din_en always (re)starts a frame; that bit is data bit 0.
    if (din_en) begin
      if (start) begin
        data_acc = 1'b1;
        word_n   = W'(din);
        cnt_n    = CW'(1);
      end else if (state_q == SHIFT) begin
        data_acc = 1'b1;
      end
`ifdef SIPO_FRAME_PARITY_EN
      else if (state_q == PARITY) begin
        load      = 1'b1;
        load_word = shreg_q;
        load_perr = ^{shreg_q, din};
      end
`endif
    end

    if (data_acc) begin
      shreg_d = word_n;
      cnt_d   = cnt_n;
      state_d = SHIFT;
      if (cnt_n == CW'(W)) begin
`ifdef SIPO_FRAME_PARITY_EN
        state_d = PARITY;
`else
        load      = 1'b1;
        load_word = word_n;
`endif
      end
    end

    // Completion: hand the word to the holding register or drop it on overrun.
    if (load) begin
      state_d = IDLE;
      cnt_d   = '0;
      if (dout_valid && !dout_ready) begin
        overrun_d = 1'b1;
      end else begin
        dout_d  = load_word;
        valid_d = 1'b1;
        perr_d  = load_perr;
      end
    end

    busy_d = (state_d != IDLE);
  end

endmodule
